// File: rtl/sar_conv_scheduler_pkg.sv
// Shared types and defaults for the SAR conversion scheduler.
// Optional averaging build: define SAR_SCHED_AVG_EN.
package sar_pkg;

   localparam int SAR_W           = 8;
   localparam int DEF_SETTLE_CYC  = 2;
   localparam int DEF_TIMEOUT_CYC = 32;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETTLE   = 3'd1,
      ST_CONVERT  = 3'd2,
      ST_WAIT_EOC = 3'd3,
      ST_STORE    = 3'd4,
      ST_NEXT     = 3'd5
   } sar_state_e;

endpackage

// File: rtl/sar_conv_scheduler_if.sv
// Scheduler <-> SAR ADC / analog mux connection.
// Optional averaging build: define SAR_SCHED_AVG_EN (no effect on this bundle).
interface sar_conv_scheduler_if #(
   parameter int NUM_CH = 4
) ();
   import sar_pkg::*;

   localparam int CH_W = $clog2(NUM_CH);

   logic              adc_cnvst;
   logic [CH_W-1:0]   ch_sel;
   logic [SAR_W-1:0]  adc_sar;
   logic              adc_eoc;

   modport master (output adc_cnvst, output ch_sel, input adc_sar, input adc_eoc);
   modport slave  (input adc_cnvst, input ch_sel, output adc_sar, output adc_eoc);

endinterface

// File: rtl/sar_conv_scheduler_chsel.sv
// Priority search for the next enabled channel (lowest enabled when i_first).
// Optional averaging build: define SAR_SCHED_AVG_EN (no effect on this module).
module sar_sched_chsel #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] i_mask,
   input  logic [CH_W-1:0]   i_cur,
   input  logic              i_first,
   output logic [CH_W-1:0]   o_next,
   output logic              o_found
);

   // Scan from the top down so the last hit is the lowest qualifying channel.
   always_comb begin
      o_next  = '0;
      o_found = 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (i_mask[NUM_CH-1-k] && (i_first || ((NUM_CH-1-k) > 32'(i_cur)))) begin
            o_next  = CH_W'(NUM_CH-1-k);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sar_conv_scheduler.sv
// Multiplexed SAR ADC scan scheduler with per-channel result store and timeout.
// Optional 4-sample averaging per channel: define SAR_SCHED_AVG_EN.
module sar_conv_scheduler
   import sar_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   localparam int CH_W       = $clog2(NUM_CH)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [NUM_CH-1:0]    i_ch_en,
   input  logic [CH_W-1:0]      i_rd_ch,
   output logic [SAR_W-1:0]     o_rd_data,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_timeout_err,
   output logic [NUM_CH-1:0]    o_res_valid,
   sar_conv_scheduler_if.master adc
);

   sar_state_e          r_state;
   logic [NUM_CH-1:0]   r_mask;
   logic [NUM_CH-1:0]   r_res_valid;
   logic [CH_W-1:0]     r_ch_sel;
   logic [3:0]          r_settle_cnt;
   logic [7:0]          r_tmo_cnt;
   logic [SAR_W-1:0]    r_result [NUM_CH];
   logic                r_done;
   logic                r_timeout_err;
`ifdef SAR_SCHED_AVG_EN
   logic [SAR_W+1:0]    r_acc;
   logic [1:0]          r_nconv;
   logic [SAR_W+1:0]    w_acc_sum;
`else
   logic [SAR_W-1:0]    r_cap;
`endif

   logic                w_search_first;
   logic [NUM_CH-1:0]   w_search_mask;
   logic [CH_W-1:0]     w_next_ch;
   logic                w_next_found;

   // In IDLE the live mask is searched from channel 0; afterwards the latched mask above ch_sel.
   assign w_search_first = (r_state == ST_IDLE);
   assign w_search_mask  = w_search_first ? i_ch_en : r_mask;

   sar_sched_chsel #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_chsel (
      .i_mask  (w_search_mask),
      .i_cur   (r_ch_sel),
      .i_first (w_search_first),
      .o_next  (w_next_ch),
      .o_found (w_next_found)
   );

`ifdef SAR_SCHED_AVG_EN
   assign w_acc_sum = r_acc + {2'b00, adc.adc_sar};
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_mask        <= '0;
         r_res_valid   <= '0;
         r_ch_sel      <= '0;
         r_settle_cnt  <= '0;
         r_tmo_cnt     <= '0;
         r_done        <= 1'b0;
         r_timeout_err <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++) r_result[i] <= '0;
`ifdef SAR_SCHED_AVG_EN
         r_acc         <= '0;
         r_nconv       <= '0;
`else
         r_cap         <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_mask        <= i_ch_en;
                  r_res_valid   <= '0;
                  r_timeout_err <= 1'b0;
                  r_settle_cnt  <= '0;
                  if (w_next_found) begin
                     r_ch_sel <= w_next_ch;
                     r_state  <= ST_SETTLE;
`ifdef SAR_SCHED_AVG_EN
                     r_acc    <= '0;
                     r_nconv  <= '0;
`endif
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            ST_SETTLE: begin
               if (r_settle_cnt == 4'(SETTLE_CYC-1)) begin
                  r_settle_cnt <= '0;
                  r_state      <= ST_CONVERT;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 4'd1;
               end
            end
            ST_CONVERT: begin
               r_tmo_cnt <= '0;
               r_state   <= ST_WAIT_EOC;
            end
            ST_WAIT_EOC: begin
               // eoc is tested before expiry so an eoc on the final cycle still succeeds.
               if (adc.adc_eoc) begin
`ifdef SAR_SCHED_AVG_EN
                  r_acc <= w_acc_sum;
                  if (r_nconv == 2'd3) begin
                     r_state <= ST_STORE;
                  end else begin
                     r_nconv <= r_nconv + 2'd1;
                     r_state <= ST_CONVERT;
                  end
`else
                  r_cap   <= adc.adc_sar;
                  r_state <= ST_STORE;
`endif
               end else if (r_tmo_cnt == 8'(TIMEOUT_CYC-1)) begin
                  r_timeout_err <= 1'b1;
                  r_state       <= ST_NEXT;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 8'd1;
               end
            end
            ST_STORE: begin
`ifdef SAR_SCHED_AVG_EN
               r_result[r_ch_sel] <= r_acc[SAR_W+1:2];
`else
               r_result[r_ch_sel] <= r_cap;
`endif
               r_res_valid[r_ch_sel] <= 1'b1;
               r_state               <= ST_NEXT;
            end
            ST_NEXT: begin
               if (w_next_found) begin
                  r_ch_sel     <= w_next_ch;
                  r_settle_cnt <= '0;
                  r_state      <= ST_SETTLE;
`ifdef SAR_SCHED_AVG_EN
                  r_acc        <= '0;
                  r_nconv      <= '0;
`endif
               end else begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign adc.adc_cnvst   = (r_state == ST_CONVERT);
   assign adc.ch_sel      = r_ch_sel;
   assign o_busy          = (r_state != ST_IDLE);
   assign o_done          = r_done;
   assign o_timeout_err   = r_timeout_err;
   assign o_res_valid     = r_res_valid;
   assign o_rd_data       = (32'(i_rd_ch) < NUM_CH) ? r_result[i_rd_ch] : '0;

endmodule

// File: tb/tb_sar_conv_scheduler.sv
// Self-checking bench for sar_conv_scheduler: vector table, ADC model with channel scoreboard.
// Build with SAR_SCHED_AVG_EN to check the averaging variant.
module tb_sar_conv_scheduler;
   import sar_pkg::*;

   localparam int NUM_CH = 4;
   localparam int SETTLE = 2;
   localparam int TMO    = 32;
`ifdef SAR_SCHED_AVG_EN
   localparam int NCONV  = 4;
`else
   localparam int NCONV  = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [3:0] ch_en = '0;
   logic [1:0] rd_ch = '0;
   logic [7:0] rd_data;
   logic       busy, done, tmo_err;
   logic [3:0] res_valid;

   sar_conv_scheduler_if #(.NUM_CH(NUM_CH)) adc_if ();

   sar_conv_scheduler #(
      .NUM_CH      (NUM_CH),
      .SETTLE_CYC  (SETTLE),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (start),
      .i_ch_en       (ch_en),
      .i_rd_ch       (rd_ch),
      .o_rd_data     (rd_data),
      .o_busy        (busy),
      .o_done        (done),
      .o_timeout_err (tmo_err),
      .o_res_valid   (res_valid),
      .adc           (adc_if.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]  en;
      logic [3:0]  mute;
      logic [31:0] data;
      int          delay;
      bit          poke;
      logic [3:0]  exp_valid;
      logic        exp_tmo;
   } vec_t;

   vec_t       vecs [7];
   logic [7:0] m_data [4];
   logic [7:0] m_res [4];
   logic [3:0] m_mute = '0;
   int         m_delay = 10;
   int         exp_ch_q [$];
   int         last_ev = -1;
   int         exp_gap = 0;
   int         mute_cnvst = -1;
   int         adc_prev = -1;
   int         adc_k = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_res(input logic [7:0] d);
`ifdef SAR_SCHED_AVG_EN
      return d + 8'd1;
`else
      return d;
`endif
   endfunction

   // ADC model: answers each cnvst after m_delay cycles; muted channels never answer.
   initial begin
      int ch;
      int t0;
      adc_if.adc_eoc = 1'b0;
      adc_if.adc_sar = '0;
      forever begin
         @(negedge clk);
         if (rst_n && adc_if.adc_cnvst === 1'b1) begin
            ch = int'(adc_if.ch_sel);
            t0 = cyc;
            if (exp_ch_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL cnvst_unexpected: got cnvst on ch %0d expected none", ch);
            end else begin
               check("cnvst_ch", ch, exp_ch_q.pop_front());
            end
            if (last_ev >= 0) check("cnvst_gap", t0 - last_ev, exp_gap);
            adc_k = (ch == adc_prev) ? adc_k + 1 : 0;
            adc_prev = ch;
            @(negedge clk);
            check("cnvst_one_cycle", adc_if.adc_cnvst, 0);
            if (m_mute[ch]) begin
               mute_cnvst = t0;
               last_ev = -1;
            end else begin
               repeat (m_delay - 1) @(negedge clk);
               adc_if.adc_sar = m_data[ch] + 8'(adc_k);
               adc_if.adc_eoc = 1'b1;
               last_ev = cyc;
               exp_gap = (adc_k < NCONV - 1) ? 1 : SETTLE + 3;
               @(negedge clk);
               adc_if.adc_eoc = 1'b0;
            end
         end
      end
   end

   task automatic read_all(input string name);
      for (int c = 0; c < NUM_CH; c++) begin
         rd_ch = 2'(c);
         #1;
         check(name, rd_data, m_res[c]);
      end
   endtask

   task automatic run_scan(input vec_t v);
      bit seen_done;
      logic tmo_prev;
      for (int c = 0; c < NUM_CH; c++) m_data[c] = v.data[c*8 +: 8];
      m_mute = v.mute;
      m_delay = v.delay;
      adc_prev = -1;
      mute_cnvst = -1;
      for (int c = 0; c < NUM_CH; c++)
         if (v.en[c]) repeat (v.mute[c] ? 1 : NCONV) exp_ch_q.push_back(c);
      @(negedge clk);
      start = 1'b1;
      ch_en = v.en;
      last_ev = cyc;
      exp_gap = SETTLE + 1;
      @(negedge clk);
      start = 1'b0;
      if (v.en == 4'b0000) begin
         check("zero_mask_done", done, 1);
         check("zero_mask_busy", busy, 0);
         @(negedge clk);
         check("zero_mask_done_pulse", done, 0);
         check("zero_mask_busy_after", busy, 0);
      end else begin
         check("busy_after_start", busy, 1);
         seen_done = 1'b0;
         tmo_prev = 1'b0;
         for (int i = 0; i < 3000 && !seen_done; i++) begin
            if (v.poke && i == 5) begin
               start = 1'b1;
               ch_en = 4'b0001;
            end else if (v.poke && i == 6) begin
               start = 1'b0;
            end
            if (tmo_err && !tmo_prev) check("timeout_latency", cyc - mute_cnvst, TMO + 1);
            tmo_prev = tmo_err;
            if (done) begin
               seen_done = 1'b1;
               check("busy_at_done", busy, 0);
            end else begin
               @(negedge clk);
            end
         end
         if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL done_wait: got no done within 3000 cycles expected a done pulse");
         end
         @(negedge clk);
         check("done_one_pulse", done, 0);
      end
      for (int c = 0; c < NUM_CH; c++)
         if (v.en[c] && !v.mute[c]) m_res[c] = exp_res(m_data[c]);
      check("res_valid", res_valid, v.exp_valid);
      check("timeout_err", tmo_err, v.exp_tmo);
      check("cnvst_count", exp_ch_q.size(), 0);
      exp_ch_q.delete();
      read_all("rd_data");
   endtask

   initial begin
      int w;
      //           en       mute     data (ch3..ch0)  dly poke valid    tmo
      vecs[0] = '{4'b1111, 4'b0000, 32'h44332211, 10, 0, 4'b1111, 1'b0};
      vecs[1] = '{4'b1010, 4'b0000, 32'hAABBCCDD, 10, 1, 4'b1010, 1'b0};
      vecs[2] = '{4'b0000, 4'b0000, 32'h00000000, 10, 0, 4'b0000, 1'b0};
      vecs[3] = '{4'b1111, 4'b0100, 32'h01020304, 10, 0, 4'b1011, 1'b1};
      vecs[4] = '{4'b0001, 4'b0000, 32'h0000005A, 32, 0, 4'b0001, 1'b0};
      vecs[5] = '{4'b1000, 4'b0000, 32'h7E000000,  1, 0, 4'b1000, 1'b0};
      vecs[6] = '{4'b0001, 4'b0000, 32'h0000000A,  4, 0, 4'b0001, 1'b0};
      for (int c = 0; c < NUM_CH; c++) m_res[c] = '0;

      #1 rst_n = 1'b0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_tmo", tmo_err, 0);
      check("rst_valid", res_valid, 0);
      check("rst_cnvst", adc_if.adc_cnvst, 0);
      check("rst_ch_sel", adc_if.ch_sel, 0);
      read_all("rst_rd_data");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_scan(vecs[i]);

      // Reset during WAIT_EOC of channel 1.
      m_mute = '0;
      m_delay = 10;
      adc_prev = -1;
      last_ev = -1;
      for (int c = 0; c < NUM_CH; c++) begin
         m_data[c] = 8'h60 + 8'(c);
         repeat (NCONV) exp_ch_q.push_back(c);
      end
      @(negedge clk);
      start = 1'b1;
      ch_en = 4'b1111;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (!(adc_if.adc_cnvst === 1'b1 && adc_if.ch_sel == 2'd1) && w < 500) begin
         @(negedge clk);
         w++;
      end
      check("reach_ch1_cnvst", adc_if.ch_sel, 1);
      repeat (3) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      check("pre_rst_valid", res_valid, 4'b0001);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_cnvst", adc_if.adc_cnvst, 0);
      check("mid_rst_ch_sel", adc_if.ch_sel, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_valid", res_valid, 0);
      check("mid_rst_tmo", tmo_err, 0);
      for (int c = 0; c < NUM_CH; c++) m_res[c] = '0;
      read_all("mid_rst_rd_data");
      exp_ch_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);

      run_scan(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by %0t expected the bench to finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sar_conv_scheduler.md
SAR_CONV_SCHEDULER -- requirements
Module: sar_conv_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of multiplexed analog channels (2..8).
REQ-002 Parameter SETTLE_CYC, default 2, mux settling cycles before each conversion (1..15).
REQ-003 Parameter TIMEOUT_CYC, default 32, maximum cycles from adc_cnvst to adc_eoc (8..255).
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle scan request; ignored while busy.
REQ-007 ch_en  in  NUM_CH  channel enable mask, sampled at scan start.
REQ-008 adc_sar  in  8  SAR ADC digital result.
REQ-009 adc_eoc  in  1  SAR ADC end-of-conversion.
REQ-010 adc_cnvst  out  1  conversion start to the SAR ADC.
REQ-011 ch_sel  out  clog2(NUM_CH)  analog mux select.
REQ-012 busy  out  1  scan in progress.
REQ-013 done  out  1  one-cycle pulse at scan end.
REQ-014 timeout_err  out  1  sticky; set on conversion timeout, cleared by the next accepted start.
REQ-015 rd_ch  in  clog2(NUM_CH)  result read select.
REQ-016 rd_data  out  8  stored result of channel rd_ch, combinational read.
REQ-017 res_valid  out  NUM_CH  per-channel result-valid flags.

Function
REQ-018 FSM states: IDLE, SETTLE, CONVERT, WAIT_EOC, STORE, NEXT.
REQ-019 IDLE: on start=1, latch ch_en, clear res_valid and timeout_err, select the lowest enabled channel, go to SETTLE; if the latched mask is 0, pulse done the next cycle and stay IDLE.
REQ-020 SETTLE: count SETTLE_CYC cycles with ch_sel stable, then go to CONVERT.
REQ-021 CONVERT: assert adc_cnvst for exactly one cycle, start the timeout counter, then go to WAIT_EOC.
REQ-022 WAIT_EOC: adc_cnvst=0; on adc_eoc=1 capture adc_sar and go to STORE; eoc arriving in the same cycle as timeout expiry counts as success.
REQ-023 Timeout: TIMEOUT_CYC cycles in WAIT_EOC without eoc sets timeout_err, leaves that channel's result and valid flag unchanged, and goes to NEXT.
REQ-024 STORE: write the captured value to result[ch_sel], set res_valid[ch_sel], go to NEXT.
REQ-025 NEXT: advance to the next higher enabled channel and go to SETTLE; after the highest enabled channel, pulse done, drop busy, go to IDLE.
REQ-026 busy=1 in every state except IDLE.
REQ-027 Latency per channel without averaging: SETTLE_CYC + 1 + (eoc wait) + 2 cycles.
REQ-028 adc_eoc seen outside WAIT_EOC is ignored.
REQ-029 start during busy is dropped; no queuing.

Reset
REQ-030 On rst=0, asynchronously: state IDLE, adc_cnvst=0, ch_sel=0, busy=0, done=0, timeout_err=0, res_valid=0, all results 0, counters 0.
REQ-031 Reset mid-scan abandons the conversion; adc_cnvst deasserts immediately.

Configuration
REQ-032 Macro SAR_SCHED_AVG_EN: when defined, each channel runs 4 back-to-back conversions (SETTLE once, then CONVERT/WAIT_EOC x4) into a 10-bit accumulator, and stores sum>>2 (truncated); any timeout aborts that channel's average.
REQ-033 When SAR_SCHED_AVG_EN is not defined, exactly one conversion runs per channel and no accumulator exists.

Structure
REQ-034 Shared package sar_pkg holds the FSM state enum, the SAR result width (8), and the default SETTLE/TIMEOUT constants.
REQ-035 One sub-module, sar_sched_chsel, computes the next enabled channel from the mask and the current channel (combinational priority search).

Verification
REQ-036 ch_en=4'b1111, adc_eoc 10 cycles after each cnvst, adc_sar=8'h11/22/33/44 -> results match, res_valid=4'hF, one done pulse, timeout_err=0.
REQ-037 ch_en=4'b1010 -> ch_sel visits only 1 then 3; res_valid=4'b1010.
REQ-038 ch_en=0 with start -> done pulse one cycle later, busy never asserted.
REQ-039 Channel 2 never returns eoc -> timeout_err=1 after 32 cycles, res_valid[2]=0, scan completes channel 3.
REQ-040 rst=0 asserted during WAIT_EOC -> all outputs at reset values immediately; next start runs a clean scan.
REQ-041 With SAR_SCHED_AVG_EN, channel 0 samples 10, 11, 12, 13 -> result[0]=11 (46>>2).
